// File: rtl/nes_cycle_scheduler.sv
// NES master-clock scheduler: derives CPU/PPU clock enables from MCLK and owns
// run/halt, single-step (cycle or frame) and the hold-in-reset window during ROM writes.
//
// state | meaning
// HALT  | stopped, no enables; waits for ENABLE
// RUN   | free-running; CPU_CE every CPU_DIV, PPU_CE every PPU_DIV MCLKs
// PARK  | manual mode idle; waits for a step key edge
// STEP  | runs like RUN until one CPU cycle (or the current frame) completes
// HOLD  | NES held in reset while the ROM programmer is writing
module nes_cycle_scheduler #(
    parameter int CPU_DIV     = 12,
    parameter int PPU_DIV     = 4,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        MANUAL,
    input  logic        STEP,
    input  logic        STEP_FRAME,
    input  logic        FRAME_START,
    input  logic        PRG_WREN,
    input  logic        CHR_WREN,
    output logic        CPU_CE,
    output logic        PPU_CE,
    output logic        NES_RESET,
    output logic [15:0] CPU_CYCLE_CNT,
    output logic [2:0]  STATE
);

    localparam int PH_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int QW   = $clog2(HOLD_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CPU_DIV - 1);
    localparam logic [QW-1:0]   Q_LIMIT  = QW'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_RUN  = 3'd1,
        S_PARK = 3'd2,
        S_STEP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_next;
    logic             r_step_prev;
    logic             r_frame_flag;
    logic             w_flag_next;
    logic [QW-1:0]    r_quiet;
    logic [QW-1:0]    w_quiet_inc;
    logic [QW-1:0]    w_quiet_next;
    logic [15:0]      r_cnt;
    logic [15:0]      w_cnt_next;
    logic             r_nes_reset;
    logic             w_active;
    logic             w_next_active;
    logic             w_phase_last;
    logic             w_strobe;
    logic             w_step_edge;
    logic             w_cpu_ce;
    logic             w_ppu_ce;

    assign w_active     = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_phase_last = (r_phase == PH_LAST);
    assign w_strobe     = PRG_WREN | CHR_WREN;
    assign w_step_edge  = STEP & ~r_step_prev;
    assign w_cpu_ce     = w_active && (r_phase == '0);
    assign w_ppu_ce     = w_active && ((32'(r_phase) % PPU_DIV) == 32'd0);

    always_comb begin
        w_next_state = r_state;
        w_quiet_inc  = w_strobe ? '0 : r_quiet + 1'b1;
        case (r_state)
            S_HALT: begin
                if (ENABLE) w_next_state = MANUAL ? S_PARK : S_RUN;
            end
            S_RUN: begin
                // a CPU cycle in flight always completes before leaving
                if ((!ENABLE || MANUAL) && w_phase_last)
                    w_next_state = ENABLE ? S_PARK : S_HALT;
            end
            S_PARK: begin
                if (!ENABLE)          w_next_state = S_HALT;
                else if (!MANUAL)     w_next_state = S_RUN;
                else if (w_step_edge) w_next_state = S_STEP;
            end
            S_STEP: begin
                if (w_phase_last && (!STEP_FRAME || r_frame_flag))
                    w_next_state = S_PARK;
            end
            S_HOLD: begin
                if (w_quiet_inc == Q_LIMIT) w_next_state = S_HALT;
            end
            default: w_next_state = S_HALT;
        endcase
        if (w_strobe) w_next_state = S_HOLD;
    end

    always_comb begin
        w_next_active = (w_next_state == S_RUN) || (w_next_state == S_STEP);
        w_phase_next  = '0;
        if (w_next_active && w_active)
            w_phase_next = w_phase_last ? '0 : r_phase + 1'b1;
        w_flag_next = 1'b0;
        if ((r_state == S_STEP) && (w_next_state == S_STEP))
            w_flag_next = r_frame_flag | FRAME_START;
        w_quiet_next = (w_next_state == S_HOLD) ? w_quiet_inc : '0;
        w_cnt_next = r_cnt;
        if (w_next_state == S_HOLD) w_cnt_next = '0;
        else if (w_cpu_ce)          w_cnt_next = r_cnt + 16'd1;
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_HALT;
            r_phase      <= '0;
            r_step_prev  <= 1'b1;
            r_frame_flag <= 1'b0;
            r_quiet      <= '0;
            r_cnt        <= '0;
            r_nes_reset  <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_phase      <= w_phase_next;
            r_step_prev  <= STEP;
            r_frame_flag <= w_flag_next;
            r_quiet      <= w_quiet_next;
            r_cnt        <= w_cnt_next;
            r_nes_reset  <= (w_next_state == S_HOLD);
        end
    end

    assign CPU_CE        = w_cpu_ce;
    assign PPU_CE        = w_ppu_ce;
    assign NES_RESET     = r_nes_reset;
    assign CPU_CYCLE_CNT = r_cnt;
    assign STATE         = r_state;

endmodule
